edge_sum_param: RTL
===================

Name: edge_sum_param

Overview:
- Parametrised, pipelined thermometer-edge encoder for the TDC delay line.
- Detects edges in an N_SUB*SUB_W-bit sampled tap word, under a runtime-selectable mode (rising / falling / both / off).
- Outputs the edge count and the sum of edge positions, offset by the block's INDEX in a cascade.
- Adds a valid pipeline, a carry-in bit from the lower-index block, and sum saturation with an overflow flag.

Parameters:
- N_SUB, 8: number of slices (>=1).
- SUB_W, 6: bits per slice.
- INDEX, 0: block position in the cascade; adds INDEX*W to every edge position.
- SUM_W, 16: width of o_sum_position.
- Derived (localparam): W = N_SUB*SUB_W; CNT_W = clog2(W+1); LAT = clog2(N_SUB)+2.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: reset, asynchronous, active-high.
- i_din, input, W: sampled tap word; bit 0 is the earliest tap.
- i_cin, input, 1: top tap bit of the lower-index block; 0 when INDEX=0.
- i_valid, input, 1: i_din, i_cin and i_mode are valid this cycle.
- i_mode, input, 2: 00 rising, 01 falling, 10 both, 11 off.
- o_sum_position, output, SUM_W: saturated sum of edge positions.
- o_num_edge, output, CNT_W: number of edges.
- o_overflow, output, 1: true sum exceeded 2^SUM_W-1.
- o_valid, output, 1: outputs updated this cycle.

Behaviour:
- Reset: all pipeline registers, o_sum_position, o_num_edge, o_overflow and o_valid are 0. Asynchronous assert, synchronous deassert at the top level.
- Edge definition, bit k (0..W-1), with d[-1] = i_cin:
  - rising: d[k]=1 and d[k-1]=0.
  - falling: d[k]=0 and d[k-1]=1.
  - both: d[k] != d[k-1].
  - off: no edges.
- Edge position = k + 1 + INDEX*W.
- Stage 1: each slice j registers its local count and its local sum (k_local+1 summed) plus count*j*SUB_W.
  - Slice j's d[-1] is the top bit of slice j-1; slice 0 uses i_cin.
- Stages 2..clog2(N_SUB)+1: registered pairwise adder tree for counts and sums.
  - Odd N_SUB: the unpaired operand is registered through unchanged.
- Final stage: full-width sum = tree_sum + count*INDEX*W.
  - If the full-width sum > 2^SUM_W-1: o_sum_position = all ones and o_overflow = 1; else the exact value and o_overflow = 0.
- Internal widths are sized so that no intermediate ever wraps; the only truncation is the explicit saturation.
- Latency: input on cycle t appears on o_* at cycle t+LAT (5 for defaults). Throughput: one sample per cycle.
- o_valid is i_valid delayed by LAT.
- o_sum_position, o_num_edge and o_overflow load only when the final-stage valid is 1; otherwise they hold their last value.
- i_mode is sampled together with i_din; a mode change affects only samples taken from that cycle on. No bubbles, no state carried between samples.
- Zero edges: sum 0, count 0, overflow 0.
- All W positions edges (both mode, alternating pattern): count = W, which must fit in CNT_W.
- Reset mid-stream: in-flight samples are discarded; o_valid is 0 until LAT cycles after the first post-reset i_valid.

Decomposition:
- Package edge_sum_pkg holds:
  - mode constants MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11;
  - the clog2 function;
  - localparam width helpers for CNT_W and internal sum width.
- Sub-module edge_slice (SUB_W, slice index, mode, carry bit) produces the registered local count and offset sum. It is instantiated N_SUB times in a generate loop. The adder tree stays in the top module.

Test Plan (defaults unless noted; outputs checked 5 cycles after i_valid):
- Rising, i_din bits 46..47 = 1, rest 0, i_cin=0 -> sum 47, count 1, overflow 0.
- Both, i_din = 48'h0000_FFFF_0000 -> edges at positions 17 and 33 -> sum 50, count 2.
- INDEX=1, rising, same word as the previous case, i_cin=0 -> sum 65, count 1.
- Both, i_din = 48'h5555_5555_5555, i_cin=0 -> count 48, sum 1176.
  - Same stimulus with SUM_W=10 -> sum 1023, overflow 1.
- Back-to-back samples with mode switching each cycle (rise, fall, off) plus an i_valid gap:
  - results appear in order, at 5-cycle latency;
  - the off sample gives 0/0;
  - outputs hold during the gap.
- Assert i_rst mid-stream with 3 samples in flight -> all outputs 0 immediately; no stale o_valid after deassert.

Source files
------------

// File: rtl/edge_sum_pkg.sv
// rtl/edge_sum_pkg.sv - mode encodings and width helpers for the TDC edge encoder
package edge_sum_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int w);
        return clog2(w + 1);
    endfunction

    // Wide enough for every edge set, including the cascade offset of each position.
    function automatic int sum_width(input int w, input int index);
        return clog2(w * (w + 1) / 2 + w * index * w + 1);
    endfunction

    function automatic int nodes_at(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/edge_sum_param_slice.sv
// rtl/edge_sum_param_slice.sv - one tap slice: registered local edge count and offset position sum
module edge_slice
    import edge_sum_pkg::*;
#(
    parameter int SUB_W     = 6,
    parameter int SLICE_IDX = 0,
    parameter int CNT_W     = 6,
    parameter int SW        = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SUB_W-1:0] i_din,
    input  logic             i_prev,
    input  logic [1:0]       i_mode,
    output logic [CNT_W-1:0] o_cnt,
    output logic [SW-1:0]    o_sum
);

    localparam int OFS = SLICE_IDX * SUB_W;

    logic [SUB_W:0]   ext;
    logic             edge_hit;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [SW-1:0]    sum_d, sum_q;

    assign ext = {i_din, i_prev};

    always_comb begin
        cnt_d    = '0;
        sum_d    = '0;
        edge_hit = 1'b0;
        for (int k = 0; k < SUB_W; k++) begin
            case (i_mode)
                MODE_RISE: edge_hit = ext[k+1] & ~ext[k];
                MODE_FALL: edge_hit = ~ext[k+1] & ext[k];
                MODE_BOTH: edge_hit = ext[k+1] ^ ext[k];
                default:   edge_hit = 1'b0;
            endcase
            if (edge_hit) begin
                cnt_d = cnt_d + CNT_W'(1);
                sum_d = sum_d + SW'(k + 1);
            end
        end
        sum_d = sum_d + SW'(cnt_d) * SW'(OFS);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_sum = sum_q;

endmodule

// File: rtl/edge_sum_param.sv
// rtl/edge_sum_param.sv - pipelined thermometer-edge count and position-sum encoder
module edge_sum_param
    import edge_sum_pkg::*;
#(
    parameter int N_SUB = 8,
    parameter int SUB_W = 6,
    parameter int INDEX = 0,
    parameter int SUM_W = 16,
    localparam int W     = N_SUB * SUB_W,
    localparam int CNT_W = cnt_width(W),
    localparam int LAT   = clog2(N_SUB) + 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [W-1:0]     i_din,
    input  logic             i_cin,
    input  logic             i_valid,
    input  logic [1:0]       i_mode,
    output logic [SUM_W-1:0] o_sum_position,
    output logic [CNT_W-1:0] o_num_edge,
    output logic             o_overflow,
    output logic             o_valid
);

    localparam int L       = clog2(N_SUB);
    localparam int TL      = (L < 1) ? 1 : L;
    localparam int TW      = sum_width(W, 0);
    localparam int SW_FULL = sum_width(W, INDEX);
    localparam int FW      = (SW_FULL > SUM_W) ? SW_FULL : SUM_W + 1;
    localparam int OFS     = INDEX * W;

    logic rst_meta_q, rst_q;

    // Reset asserts at once but releases on a clock edge so no flop sees a runt deassert.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_meta_q <= 1'b1;
            rst_q      <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_q      <= rst_meta_q;
        end
    end

    logic [W:0]       ext;
    logic [CNT_W-1:0] s_cnt [N_SUB];
    logic [TW-1:0]    s_sum [N_SUB];

    assign ext = {i_din, i_cin};

    for (genvar j = 0; j < N_SUB; j++) begin : g_slice
        edge_slice #(
            .SUB_W     (SUB_W),
            .SLICE_IDX (j),
            .CNT_W     (CNT_W),
            .SW        (TW)
        ) u_slice (
            .i_clk  (i_clk),
            .i_rst  (rst_q),
            .i_din  (i_din[j*SUB_W +: SUB_W]),
            .i_prev (ext[j*SUB_W]),
            .i_mode (i_mode),
            .o_cnt  (s_cnt[j]),
            .o_sum  (s_sum[j])
        );
    end

    logic [CNT_W-1:0] t_cnt_q [1:TL][N_SUB];
    logic [TW-1:0]    t_sum_q [1:TL][N_SUB];
    logic [CNT_W-1:0] lvl_cnt [0:L][N_SUB];
    logic [TW-1:0]    lvl_sum [0:L][N_SUB];

    // Row 0 is the slice outputs, row l the registered tree level l.
    always_comb begin
        lvl_cnt[0] = s_cnt;
        lvl_sum[0] = s_sum;
        for (int l = 1; l <= L; l++) begin
            lvl_cnt[l] = t_cnt_q[l];
            lvl_sum[l] = t_sum_q[l];
        end
    end

    always_ff @(posedge i_clk or posedge rst_q) begin
        if (rst_q) begin
            for (int l = 1; l <= TL; l++) begin
                for (int i = 0; i < N_SUB; i++) begin
                    t_cnt_q[l][i] <= '0;
                    t_sum_q[l][i] <= '0;
                end
            end
        end else begin
            for (int l = 1; l <= L; l++) begin
                for (int i = 0; i < N_SUB; i++) begin
                    if (2*i + 1 < nodes_at(N_SUB, l - 1)) begin
                        t_cnt_q[l][i] <= lvl_cnt[l-1][(2*i) % N_SUB] + lvl_cnt[l-1][(2*i+1) % N_SUB];
                        t_sum_q[l][i] <= lvl_sum[l-1][(2*i) % N_SUB] + lvl_sum[l-1][(2*i+1) % N_SUB];
                    end else if (2*i < nodes_at(N_SUB, l - 1)) begin
                        t_cnt_q[l][i] <= lvl_cnt[l-1][(2*i) % N_SUB];
                        t_sum_q[l][i] <= lvl_sum[l-1][(2*i) % N_SUB];
                    end else begin
                        t_cnt_q[l][i] <= '0;
                        t_sum_q[l][i] <= '0;
                    end
                end
            end
        end
    end

    logic [L:0] vld_q;

    always_ff @(posedge i_clk or posedge rst_q) begin
        if (rst_q) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= i_valid;
            for (int i = 1; i <= L; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    logic [CNT_W-1:0] tree_cnt;
    logic [FW-1:0]    full_sum;
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q, valid_q;

    assign tree_cnt = lvl_cnt[L][0];
    assign full_sum = FW'(lvl_sum[L][0]) + FW'(tree_cnt) * FW'(OFS);

    always_ff @(posedge i_clk or posedge rst_q) begin
        if (rst_q) begin
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= vld_q[L];
            if (vld_q[L]) begin
                cnt_q <= tree_cnt;
                if (|full_sum[FW-1:SUM_W]) begin
                    sum_q <= '1;
                    ovf_q <= 1'b1;
                end else begin
                    sum_q <= full_sum[SUM_W-1:0];
                    ovf_q <= 1'b0;
                end
            end
        end
    end

    assign o_sum_position = sum_q;
    assign o_num_edge     = cnt_q;
    assign o_overflow     = ovf_q;
    assign o_valid        = valid_q;

endmodule
